// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for one FIFO shared by NUM_REQ requesters.
// A granted requester writes up to MAX_BURST words back-to-back; the burst
// stalls while the FIFO is full and ends early when the holder drops req.
// Ports:
//   w_clk      write-domain clock (posedge)
//   rst        asynchronous active-low reset
//   req        per-requester "word available" flags
//   din_bus    packed per-requester data, slice i = din_bus[i*DATA_WIDTH +: DATA_WIDTH]
//   fifo_full  FIFO full flag (back-pressure)
//   we, din    FIFO write enable / write data (combinational)
//   ack        one-hot "slice i consumed this cycle" (combinational)
//   grant_id   current/last grant holder (registered)
//   busy       high while a burst is in progress (combinational from state)
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4,
  localparam int unsigned GW        = $clog2(NUM_REQ)
) (
  input  logic                          w_clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] din_bus,
  input  logic                          fifo_full,
  output logic                          we,
  output logic [DATA_WIDTH-1:0]         din,
  output logic [NUM_REQ-1:0]            ack,
  output logic [GW-1:0]                 grant_id,
  output logic                          busy
);

  localparam int unsigned CW = $clog2(MAX_BURST) + 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t          r_state;
  logic [GW-1:0]   r_rr_ptr;
  logic [GW-1:0]   r_grant_id;
  logic [CW-1:0]   r_burst_cnt;

  logic            w_pick_valid;
  logic [GW-1:0]   w_pick_id;
  logic [GW-1:0]   w_idx;
  logic [GW-1:0]   w_next_rr;
  logic            w_last_word;

  // First requester at or after r_rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    w_pick_valid = 1'b0;
    w_pick_id    = '0;
    w_idx        = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      w_idx = GW'((32'(r_rr_ptr) + 32'(k)) % NUM_REQ);
      if (!w_pick_valid && req[w_idx]) begin
        w_pick_valid = 1'b1;
        w_pick_id    = w_idx;
      end
    end
  end

  // Pointer moves just past the holder so every requester gets its turn.
  assign w_next_rr   = (r_grant_id == GW'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;
  assign w_last_word = (r_burst_cnt == CW'(MAX_BURST - 1));

  // Output decode; state resets asynchronously so we/ack drop with rst.
  assign busy     = (r_state == S_BURST);
  assign we       = busy & req[r_grant_id] & ~fifo_full;
  assign ack      = we ? (NUM_REQ'(1) << r_grant_id) : '0;
  assign grant_id = r_grant_id;

  // Data mux from the granted slice.
  always_comb begin
    din = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (r_grant_id == GW'(i)) begin
        din = din_bus[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Arbitration FSM.
  always_ff @(posedge w_clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_grant_id  <= '0;
      r_burst_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_valid) begin
            r_grant_id  <= w_pick_id;
            r_burst_cnt <= '0;
            r_state     <= S_BURST;
          end
        end
        S_BURST: begin
          if (!req[r_grant_id]) begin
            // Holder withdrew: end the burst without a write.
            r_state  <= S_IDLE;
            r_rr_ptr <= w_next_rr;
          end else if (!fifo_full) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
            if (w_last_word) begin
              r_state  <= S_IDLE;
              r_rr_ptr <= w_next_rr;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned MB = 4;
  localparam int unsigned GW = 2;

  logic              w_clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  din_bus;
  logic              fifo_full;
  logic              we;
  logic [DW-1:0]     din;
  logic [NR-1:0]     ack;
  logic [GW-1:0]     grant_id;
  logic              busy;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .w_clk(w_clk), .rst(rst), .req(req), .din_bus(din_bus), .fifo_full(fifo_full),
    .we(we), .din(din), .ack(ack), .grant_id(grant_id), .busy(busy)
  );

  always #5 w_clk = ~w_clk;

  // Requesters: words still to deliver and the word currently presented.
  int          rem [NR];
  logic [DW-1:0] word [NR];
  int          cyc;
  int          full_from, full_to;
  bit          full_rand;

  // Reference model: is a burst open, who holds it, words written so far,
  // and where the next round-robin search starts.
  bit          m_busy;
  int          m_hold;
  int          m_done;
  int          m_next;

  int          ack_cyc [$];
  int          grant_q [$];
  int          wr_cnt [NR];
  int          mism, din_err, oh_err, stall_obs;

  int          n_pass = 0;
  int          n_total = 0;

  function automatic string q2s(input int q [$]);
    string s = "";
    foreach (q[i]) s = $sformatf("%s%0d ", s, q[i]);
    return s;
  endfunction

  task automatic clear_logs();
    ack_cyc.delete();
    grant_q.delete();
    for (int i = 0; i < NR; i++) wr_cnt[i] = 0;
    mism = 0; din_err = 0; oh_err = 0; stall_obs = 0; cyc = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    fifo_full = 1'b0;
    din_bus = '0;
    for (int i = 0; i < NR; i++) begin
      rem[i] = 0;
      word[i] = DW'($urandom);
    end
    m_busy = 0; m_hold = 0; m_done = 0; m_next = 0;
    full_from = -1; full_to = -1; full_rand = 0;
    clear_logs();
    repeat (2) @(negedge w_clk);
    rst = 1'b1;
  endtask

  // Drive one cycle per iteration, compare outputs to the model, advance model.
  task automatic run_cycles(input int n);
    bit            e_we;
    logic [NR-1:0] e_ack;
    bit            found;
    int            idx;
    for (int c = 0; c < n; c++) begin
      @(negedge w_clk);
      for (int i = 0; i < NR; i++) begin
        req[i] = (rem[i] > 0);
        din_bus[i*DW +: DW] = word[i];
      end
      if (full_rand) fifo_full = ($urandom_range(3) == 0);
      else           fifo_full = (cyc >= full_from) && (cyc <= full_to);
      #1;
      e_we  = m_busy && req[m_hold] && !fifo_full;
      e_ack = '0;
      if (e_we) e_ack[m_hold] = 1'b1;
      if (we !== e_we || ack !== e_ack || busy !== m_busy || grant_id !== GW'(m_hold)) mism++;
      if (e_we && din !== word[m_hold]) din_err++;
      if (we !== (|ack) || (ack !== '0 && !$onehot(ack))) oh_err++;
      if (busy === 1'b1 && we === 1'b0) stall_obs++;
      if (e_we) begin
        ack_cyc.push_back(cyc);
        wr_cnt[m_hold]++;
        rem[m_hold]--;
        word[m_hold] = DW'($urandom);
      end
      if (!m_busy) begin
        found = 0;
        for (int k = 0; k < NR; k++) begin
          idx = (m_next + k) % NR;
          if (!found && req[idx]) begin
            found = 1; m_hold = idx; m_done = 0; m_busy = 1;
            grant_q.push_back(idx);
          end
        end
      end else if (!req[m_hold]) begin
        m_busy = 0; m_next = (m_hold + 1) % NR;
      end else if (e_we) begin
        m_done++;
        if (m_done == MB) begin
          m_busy = 0; m_next = (m_hold + 1) % NR;
        end
      end
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req = '1;
    fifo_full = 1'b0;
    din_bus = '1;
    repeat (2) @(negedge w_clk);
    #1;
    n_total++; if (we !== 1'b0) $display("FAIL reset_we: got %b expected 0", we); else n_pass++;
    n_total++; if (ack !== '0) $display("FAIL reset_ack: got %b expected 0000", ack); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_total++; if (grant_id !== '0) $display("FAIL reset_grant_id: got %0d expected 0", grant_id); else n_pass++;
  endtask

  task automatic test_single();
    string got;
    do_reset();
    rem[0] = 6;
    run_cycles(12);
    n_total++; if (mism !== 0) $display("FAIL single_model: got %0d cycle mismatches expected 0", mism); else n_pass++;
    got = q2s(ack_cyc);
    n_total++; if (got != "1 2 3 4 6 7 ") $display("FAIL single_ack_cycles: got '%s' expected '1 2 3 4 6 7 '", got); else n_pass++;
    got = q2s(grant_q);
    n_total++; if (got != "0 0 ") $display("FAIL single_grants: got '%s' expected '0 0 '", got); else n_pass++;
  endtask

  task automatic test_all_requesters();
    string got;
    string cnt;
    do_reset();
    rem[0] = 8; rem[1] = 4; rem[2] = 4; rem[3] = 4;
    run_cycles(30);
    n_total++; if (mism !== 0) $display("FAIL all_model: got %0d cycle mismatches expected 0", mism); else n_pass++;
    n_total++; if (din_err !== 0) $display("FAIL all_din: got %0d wrong words expected 0", din_err); else n_pass++;
    got = q2s(grant_q);
    n_total++; if (got != "0 1 2 3 0 ") $display("FAIL all_grant_order: got '%s' expected '0 1 2 3 0 '", got); else n_pass++;
    cnt = "";
    for (int i = 0; i < NR; i++) cnt = $sformatf("%s%0d ", cnt, wr_cnt[i]);
    n_total++; if (cnt != "8 4 4 4 ") $display("FAIL all_write_counts: got '%s' expected '8 4 4 4 '", cnt); else n_pass++;
  endtask

  task automatic test_full_stall();
    string got;
    do_reset();
    rem[1] = 4;
    full_from = 3; full_to = 5;
    run_cycles(10);
    n_total++; if (mism !== 0) $display("FAIL stall_model: got %0d cycle mismatches expected 0", mism); else n_pass++;
    got = q2s(ack_cyc);
    n_total++; if (got != "1 2 6 7 ") $display("FAIL stall_ack_cycles: got '%s' expected '1 2 6 7 '", got); else n_pass++;
    n_total++; if (wr_cnt[1] !== 4) $display("FAIL stall_total: got %0d expected 4", wr_cnt[1]); else n_pass++;
    n_total++; if (stall_obs !== 3) $display("FAIL stall_busy_no_we: got %0d expected 3", stall_obs); else n_pass++;
  endtask

  task automatic test_early_drop();
    string got;
    do_reset();
    rem[2] = 2; rem[3] = 4;
    run_cycles(12);
    n_total++; if (mism !== 0) $display("FAIL drop_model: got %0d cycle mismatches expected 0", mism); else n_pass++;
    got = q2s(ack_cyc);
    n_total++; if (got != "1 2 5 6 7 8 ") $display("FAIL drop_ack_cycles: got '%s' expected '1 2 5 6 7 8 '", got); else n_pass++;
    got = q2s(grant_q);
    n_total++; if (got != "2 3 ") $display("FAIL drop_grants: got '%s' expected '2 3 '", got); else n_pass++;
  endtask

  task automatic test_rr_order();
    string got;
    do_reset();
    rem[2] = 4;
    run_cycles(5);
    rem[0] = 4; rem[3] = 4;
    run_cycles(12);
    n_total++; if (mism !== 0) $display("FAIL rr_model: got %0d cycle mismatches expected 0", mism); else n_pass++;
    got = q2s(grant_q);
    n_total++; if (got != "2 3 0 ") $display("FAIL rr_grant_order: got '%s' expected '2 3 0 '", got); else n_pass++;
    got = q2s(ack_cyc);
    n_total++; if (got != "1 2 3 4 6 7 8 9 11 12 13 14 ")
      $display("FAIL rr_ack_cycles: got '%s' expected '1 2 3 4 6 7 8 9 11 12 13 14 '", got); else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    rem[1] = 4;
    run_cycles(5);
    rem[2] = 4;
    run_cycles(3);
    @(negedge w_clk);
    for (int i = 0; i < NR; i++) begin
      req[i] = (rem[i] > 0);
      din_bus[i*DW +: DW] = word[i];
    end
    #1;
    n_total++; if (we !== 1'b1 || grant_id !== 2'd2) $display("FAIL midrst_pre_we: got we=%b gid=%0d expected we=1 gid=2", we, grant_id); else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_total++; if (we !== 1'b0) $display("FAIL midrst_we: got %b expected 0", we); else n_pass++;
    n_total++; if (ack !== '0) $display("FAIL midrst_ack: got %b expected 0000", ack); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busy); else n_pass++;
    n_total++; if (grant_id !== '0) $display("FAIL midrst_grant_id: got %0d expected 0", grant_id); else n_pass++;
    m_busy = 0; m_hold = 0; m_done = 0; m_next = 0;
    @(posedge w_clk);
    #2 rst = 1'b1;
    clear_logs();
    rem[0] = 2;
    run_cycles(12);
    n_total++; if (grant_q.size() == 0 || grant_q[0] !== 0)
      $display("FAIL midrst_next_grant: got '%s' expected first grant 0", q2s(grant_q)); else n_pass++;
    n_total++; if (mism !== 0) $display("FAIL midrst_model: got %0d cycle mismatches expected 0", mism); else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    full_rand = 1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++)
        if (rem[i] == 0 && $urandom_range(3) == 0) rem[i] = $urandom_range(6, 1);
      run_cycles(1);
    end
    n_total++; if (mism !== 0) $display("FAIL random_model: got %0d cycle mismatches expected 0", mism); else n_pass++;
    n_total++; if (din_err !== 0) $display("FAIL random_din: got %0d wrong words expected 0", din_err); else n_pass++;
    n_total++; if (oh_err !== 0) $display("FAIL random_onehot: got %0d bad ack/we cycles expected 0", oh_err); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_requesters();
    test_full_stall();
    test_early_drop();
    test_rr_order();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
